usb_tx_phy: RTL

USB_TX_PHY -- requirements
Module: usb_tx_phy

---
 rtl/usb_tx_phy.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/usb_tx_phy.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : usb_tx_phy
// Brief    : USB full/low-speed transmit PHY. Sends SYNC, NRZI-encoded and
//            bit-stuffed data bytes (LSB first), then SE0/SE0/J end-of-packet.
//            Optional low-speed support is enabled by defining USB_TX_LS_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------

package usb_tx_phy_pkg;
  typedef logic [1:0] d_port_t;
endpackage

module usb_tx_phy
  import usb_tx_phy_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 4,
  parameter int CLKS_PER_BIT_LS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ls,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output d_port_t    d_o,
  output logic       d_en
);

`ifdef USB_TX_LS_EN
  localparam int MAX_CLKS = (CLKS_PER_BIT > CLKS_PER_BIT_LS) ? CLKS_PER_BIT : CLKS_PER_BIT_LS;
`else
  localparam int MAX_CLKS = CLKS_PER_BIT;
`endif
  localparam int CW = $clog2(MAX_CLKS);
  localparam logic [CW-1:0] FS_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;     // clocks elapsed in the current bit time
  logic [7:0]    sr_q;      // current byte; bit 0 is the bit on the wire
  logic [2:0]    idx_q;     // index of current data bit (EOP: bit-time count)
  logic [2:0]    ones_q;    // consecutive ones transmitted so far
  d_port_t       d_o_q;
  logic          d_en_q;

  d_port_t       j_lvl;     // J for the latched speed
  d_port_t       k_start;   // K for the speed being latched at packet start
  logic [CW-1:0] last_cnt;
  logic          strobe;
  logic          need_stuff;
  logic          at_bound;
  logic          next_bit_d;

`ifdef USB_TX_LS_EN
  localparam logic [CW-1:0] LS_LAST = CW'(CLKS_PER_BIT_LS - 1);
  logic ls_q;
  assign j_lvl    = ls_q ? 2'b01 : 2'b10;
  assign k_start  = ls   ? 2'b10 : 2'b01;
  assign last_cnt = ls_q ? LS_LAST : FS_LAST;
`else
  // Low-speed disabled: ls and CLKS_PER_BIT_LS have no effect.
  logic unused_ls;
  assign unused_ls = ls ^ CLKS_PER_BIT_LS[0];
  assign j_lvl     = 2'b10;
  assign k_start   = 2'b01;
  assign last_cnt  = FS_LAST;
`endif

  // Bit strobe, stuffing decision and byte-boundary handshake.
  always_comb begin
    strobe     = (state_q != IDLE) && (cnt_q == last_cnt);
    need_stuff = (ones_q == 3'd6);
    at_bound   = strobe && ((state_q == SYNC) || (state_q == DATA)) &&
                 !need_stuff && (idx_q == 3'd7);
    tx_ready   = at_bound && tx_valid;
    // Next data bit: first bit of a new byte, or the next bit of this one.
    next_bit_d = (idx_q == 3'd7) ? tx_data[0] : sr_q[1];
  end

  assign d_o  = d_o_q;
  assign d_en = d_en_q;

  // Packet sequencer: SYNC and DATA share the NRZI/stuffing path; SYNC is
  // simply the byte 0x80 loaded at packet start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      idx_q   <= '0;
      ones_q  <= '0;
      d_o_q   <= 2'b10;
      d_en_q  <= 1'b0;
`ifdef USB_TX_LS_EN
      ls_q    <= 1'b0;
`endif
    end else begin
      cnt_q <= (state_q == IDLE || strobe) ? '0 : cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          d_en_q <= 1'b0;
          d_o_q  <= j_lvl;
          idx_q  <= '0;
          ones_q <= '0;
          if (tx_valid) begin
            state_q <= SYNC;
            d_en_q  <= 1'b1;
            d_o_q   <= k_start;   // SYNC bit 0 is a zero: J -> K
            sr_q    <= 8'h80;
`ifdef USB_TX_LS_EN
            ls_q    <= ls;
`endif
          end
        end
        SYNC, DATA: begin
          if (strobe) begin
            if (need_stuff) begin
              d_o_q  <= ~d_o_q;
              ones_q <= '0;
            end else if (idx_q == 3'd7 && !tx_valid) begin
              state_q <= EOP_SE0;
              d_o_q   <= 2'b00;
              idx_q   <= '0;
              ones_q  <= '0;
            end else begin
              if (idx_q == 3'd7) begin
                state_q <= DATA;
                sr_q    <= tx_data;
              end else begin
                sr_q    <= sr_q >> 1;
              end
              idx_q  <= idx_q + 3'd1;
              d_o_q  <= next_bit_d ? d_o_q : ~d_o_q;
              ones_q <= next_bit_d ? ones_q + 3'd1 : 3'd0;
            end
          end
        end
        EOP_SE0: begin
          if (strobe) begin
            if (idx_q == 3'd1) begin
              state_q <= EOP_J;
              d_o_q   <= j_lvl;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        EOP_J: begin
          if (strobe) begin
            state_q <= IDLE;
            d_en_q  <= 1'b0;
            d_o_q   <= j_lvl;
          end
        end
        default: begin
          state_q <= IDLE;
          d_en_q  <= 1'b0;
          d_o_q   <= j_lvl;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
